// File: rtl/cgra_pkg.sv
// Shared types and constants for the CGRA execution sequencer.
package cgra_pkg;

  localparam int unsigned SEQ_CNT_W   = 16;
  localparam int unsigned SEQ_MAX_OUT = 32;

  typedef enum logic [2:0] {
    S_SEQ_IDLE,
    S_SEQ_CLEAR,
    S_SEQ_CONF,
    S_SEQ_EXEC,
    S_SEQ_DONE
  } seq_state_t;

  // out_mask is sized for the largest supported NUM_OUT; unused upper bits stay zero.
  typedef struct packed {
    logic                   reconf;
    logic [SEQ_MAX_OUT-1:0] out_mask;
  } seq_cmd_t;

  function automatic logic mask_met(input logic [SEQ_MAX_OUT-1:0] done,
                                    input logic [SEQ_MAX_OUT-1:0] mask);
    return (done & mask) == mask;
  endfunction

endpackage

// File: rtl/cgra_seq_fifo.sv
// Synchronous command FIFO with occupancy output; no fall-through, flush empties it.
module cgra_seq_fifo
  import cgra_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  seq_cmd_t                 data_i,
  input  logic                     pop_i,
  output seq_cmd_t                 data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  seq_cmd_t        mem_q [DEPTH];
  seq_cmd_t        mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     level_q, level_d;
  logic            push_en, pop_en;

  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    push_en  = push_i & ~full_o;
    pop_en   = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      level_d = level_q + {{PW{1'b0}}, push_en} - {{PW{1'b0}}, pop_en};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/cgra_exec_sequencer.sv
// Queued kernel-launch sequencer: clear, optional reconfig, execute, completion/irq.
// Optional watchdog enabled by defining CGRA_SEQ_WATCHDOG_EN.
module cgra_exec_sequencer
  import cgra_pkg::*;
#(
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned TIMEOUT_W   = 24
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic                           cmd_reconf_i,
  input  logic [NUM_OUT-1:0]             cmd_out_mask_i,
  output logic                           conf_start_o,
  input  logic                           conf_done_i,
  output logic                           clear_o,
  output logic                           exec_o,
  input  logic [NUM_OUT-1:0]             out_done_i,
  input  logic                           abort_i,
  input  logic                           irq_mode_i,
  input  logic                           irq_en_i,
  input  logic                           irq_clr_i,
  output logic                           irq_o,
  output logic                           busy_o,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level_o,
  output logic [15:0]                    done_count_o,
  output logic                           aborted_o,
  input  logic [TIMEOUT_W-1:0]           timeout_cycles_i,
  output logic                           timeout_o
);

  seq_state_t             state_q, state_d;
  seq_cmd_t               cmd_q, cmd_d, cmd_in, fifo_head;
  logic [SEQ_CNT_W-1:0]   done_cnt_q, done_cnt_d;
  logic                   pending_q, pending_d;
  logic                   aborted_q, aborted_d;
  logic                   abort_clr_q, abort_clr_d;
  logic                   conf_first_q, conf_first_d;
  logic [SEQ_MAX_OUT-1:0] out_done_w;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic                   active, kern_abort, flush, wd_hit, complete;

  always_comb begin
    cmd_in                   = '0;
    cmd_in.reconf            = cmd_reconf_i;
    cmd_in.out_mask[NUM_OUT-1:0] = cmd_out_mask_i;
    out_done_w               = '0;
    out_done_w[NUM_OUT-1:0]  = out_done_i;
  end

  assign active = (state_q == S_SEQ_CLEAR) || (state_q == S_SEQ_CONF) ||
                  (state_q == S_SEQ_EXEC);

`ifdef CGRA_SEQ_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d, wd_inc;
  logic                 wd_counting;
  logic                 timeout_q, timeout_d;

  // Compare against the count including the current cycle so a limit of N
  // aborts on the Nth CONF/EXEC cycle.
  always_comb begin
    wd_counting = (state_q == S_SEQ_CONF) || (state_q == S_SEQ_EXEC);
    wd_inc      = wd_cnt_q + TIMEOUT_W'(1);
    wd_hit      = wd_counting && (timeout_cycles_i != '0) && (wd_inc == timeout_cycles_i);
    wd_cnt_d    = wd_cnt_q;
    if (state_q == S_SEQ_CLEAR) wd_cnt_d = '0;
    else if (wd_counting)       wd_cnt_d = wd_inc;
    timeout_d = timeout_q;
    if (wd_hit)         timeout_d = 1'b1;
    else if (irq_clr_i) timeout_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles_i;
  assign wd_hit         = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  assign kern_abort = (abort_i & active) | wd_hit;
  assign flush      = abort_i | wd_hit;

  cgra_seq_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .push_i  (cmd_valid_i & ~flush),
    .data_i  (cmd_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (queue_level_o)
  );

  // Completion bookkeeping happens on the EXEC->DONE edge so that irq_o and
  // done_count_o are already updated in the DONE cycle, as exec_o falls.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    done_cnt_d   = done_cnt_q;
    pending_d    = pending_q;
    aborted_d    = aborted_q;
    abort_clr_d  = 1'b0;
    conf_first_d = 1'b0;
    fifo_pop     = 1'b0;
    complete     = 1'b0;

    unique case (state_q)
      S_SEQ_IDLE: begin
        if (!fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          state_d  = S_SEQ_CLEAR;
        end
      end
      S_SEQ_CLEAR: begin
        if (cmd_q.reconf) begin
          state_d      = S_SEQ_CONF;
          conf_first_d = 1'b1;
        end else begin
          state_d = S_SEQ_EXEC;
        end
      end
      S_SEQ_CONF: begin
        if (conf_done_i) state_d = S_SEQ_EXEC;
      end
      S_SEQ_EXEC: begin
        if (mask_met(out_done_w, cmd_q.out_mask)) begin
          state_d  = S_SEQ_DONE;
          complete = 1'b1;
        end
      end
      S_SEQ_DONE: state_d = S_SEQ_IDLE;
      default:    state_d = S_SEQ_IDLE;
    endcase

    if (kern_abort) begin
      state_d      = S_SEQ_IDLE;
      conf_first_d = 1'b0;
      complete     = 1'b0;
      abort_clr_d  = 1'b1;
    end

    if (complete) done_cnt_d = done_cnt_q + SEQ_CNT_W'(1);

    if (kern_abort || (complete && (!irq_mode_i || fifo_empty))) pending_d = 1'b1;
    else if (irq_clr_i)                                            pending_d = 1'b0;

    if (kern_abort)     aborted_d = 1'b1;
    else if (irq_clr_i) aborted_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_SEQ_IDLE;
      cmd_q        <= '0;
      done_cnt_q   <= '0;
      pending_q    <= 1'b0;
      aborted_q    <= 1'b0;
      abort_clr_q  <= 1'b0;
      conf_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      done_cnt_q   <= done_cnt_d;
      pending_q    <= pending_d;
      aborted_q    <= aborted_d;
      abort_clr_q  <= abort_clr_d;
      conf_first_q <= conf_first_d;
    end
  end

  assign cmd_ready_o  = ~fifo_full & ~flush;
  assign clear_o      = (state_q == S_SEQ_CLEAR) | abort_clr_q;
  assign conf_start_o = (state_q == S_SEQ_CONF) & conf_first_q;
  assign exec_o       = (state_q == S_SEQ_EXEC);
  assign irq_o        = pending_q & irq_en_i;
  assign busy_o       = (state_q != S_SEQ_IDLE) | ~fifo_empty;
  assign done_count_o = done_cnt_q;
  assign aborted_o    = aborted_q;

endmodule
